// File: rtl/seven_segment_capture.sv
// Snoops a multiplexed active-low 7-segment bus, decodes each digit glyph back to a hex
// nibble and publishes one complete scan of DIGITS digits as a parallel frame.
module seven_segment_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    output logic [4*DIGITS-1:0]   value,
    output logic                  valid,
    output logic                  err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic {COLLECT, PUBLISH} state_t;

    state_t state, state_nxt;

    logic [DIGITS-1:0]   an_q, an_p;
    logic [6:0]          seg_q, seg_p;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic                stable_eq;
    logic                sample;
    logic [DIGITS-1:0]   an_low;
    logic                onehot;
    logic                hit;
    logic [DIGITS-1:0]   hitmask;
    logic [3:0]          nib;
    logic                inv;
    logic [4*DIGITS-1:0] shadow;
    logic [DIGITS-1:0]   seen;
    logic                frame_err;
    logic                frame_done;

    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = 5'h00;
            7'b1111001: r = 5'h01;
            7'b0100100: r = 5'h02;
            7'b0110000: r = 5'h03;
            7'b0011001: r = 5'h04;
            7'b0010010: r = 5'h05;
            7'b0000010: r = 5'h06;
            7'b1111000: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0010000: r = 5'h09;
            7'b0001000: r = 5'h0A;
            7'b0000011: r = 5'h0B;
            7'b1000110: r = 5'h0C;
            7'b0100001: r = 5'h0D;
            7'b0000110: r = 5'h0E;
            7'b0001110: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    // Sample fires only on the transition into saturation, so a long dwell samples once.
    always_comb begin
        stable_eq = ({an_q, seg_q} == {an_p, seg_p});
        if (!stable_eq)
            cnt_nxt = '0;
        else if (cnt == CW'(STABLE_CYCLES))
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + 1'b1;
        sample = stable_eq && (cnt == CW'(STABLE_CYCLES - 1));
    end

    always_comb begin
        an_low     = ~an_q;
        onehot     = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
        hit        = sample && onehot;
        hitmask    = hit ? an_low : '0;
        {inv, nib} = decode(seg_q);
        frame_done = ((seen | hitmask) == '1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (frame_done) state_nxt = PUBLISH;
            PUBLISH: state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        valid = (state == PUBLISH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_q      <= '1;
            seg_q     <= '1;
            an_p      <= '1;
            seg_p     <= '1;
            cnt       <= '0;
            shadow    <= '0;
            seen      <= '0;
            frame_err <= 1'b0;
            value     <= '0;
            err       <= 1'b0;
        end else begin
            an_q  <= an_n;
            seg_q <= seg_n;
            an_p  <= an_q;
            seg_p <= seg_q;
            cnt   <= cnt_nxt;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (hitmask[i])
                    shadow[4*i +: 4] <= inv ? 4'h0 : nib;
            end
            if (state == PUBLISH) begin
                value     <= shadow;
                err       <= frame_err;
                seen      <= hitmask;
                frame_err <= hit && inv;
            end else if (hit) begin
                seen      <= seen | hitmask;
                frame_err <= frame_err | inv;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Drives directed and random display scans into seven_segment_capture and checks every
// cycle against a dwell-length based model of sampling and frame assembly.
module tb_seven_segment_capture;

    localparam int D = 4;
    localparam int S = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    seg_n;
    logic [D-1:0]  an_n;
    logic [4*D-1:0] value;
    logic          valid;
    logic          err;

    int ncmp  = 0;
    int nfail = 0;

    seven_segment_capture #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .seg_n (seg_n),
        .an_n  (an_n),
        .value (value),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model: a digit is captured when its input pattern has been held for S+1
    // cycles; a completed frame shows valid two cycles later and value one cycle after that.
    int          cyc = 0;
    logic [10:0] last;
    int          run;
    logic [15:0] m_shadow;
    logic [3:0]  m_seen;
    logic        m_ferr;
    logic        pend_on;
    int          pend_cyc;
    logic [15:0] pend_value;
    logic        pend_err;
    logic [15:0] exp_value;
    logic        exp_err;
    int          nvalid = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic model_reset();
        last      = '1;
        run       = 0;
        m_shadow  = '0;
        m_seen    = '0;
        m_ferr    = 1'b0;
        pend_on   = 1'b0;
        pend_cyc  = 0;
        exp_value = '0;
        exp_err   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        an_n  = '1;
        seg_n = '1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("reset_value", value, 16'h0);
        chk("reset_err", {15'b0, err}, 16'h0);
        chk("reset_valid", {15'b0, valid}, 16'h0);
    endtask

    task automatic tick(input logic [3:0] an, input logic [6:0] seg);
        logic [3:0] low;
        logic [3:0] nib;
        logic       inv;
        int         j;
        @(posedge clk);
        #1;
        cyc++;
        if (valid) nvalid++;
        if (pend_on && cyc == pend_cyc + 1) begin
            exp_value = pend_value;
            exp_err   = pend_err;
            pend_on   = 1'b0;
        end
        chk("valid", {15'b0, valid}, {15'b0, (pend_on && cyc == pend_cyc)});
        chk("value", value, exp_value);
        chk("err", {15'b0, err}, {15'b0, exp_err});
        an_n  = an;
        seg_n = seg;
        if ({an, seg} == last) run++;
        else begin
            run  = 1;
            last = {an, seg};
        end
        if (run == S + 1) begin
            low = ~an;
            if ($countones(low) == 1) begin
                j = 0;
                for (int k = 0; k < 4; k++) if (low[k]) j = k;
                inv = 1'b1;
                nib = 4'h0;
                for (int k = 0; k < 16; k++) begin
                    if (tbl[k] == seg) begin
                        inv = 1'b0;
                        nib = 4'(k);
                    end
                end
                m_shadow[4*j +: 4] = nib;
                m_seen[j] = 1'b1;
                m_ferr = m_ferr | inv;
                if (m_seen == 4'hF) begin
                    pend_on    = 1'b1;
                    pend_cyc   = cyc + 2;
                    pend_value = m_shadow;
                    pend_err   = m_ferr;
                    m_seen     = '0;
                    m_ferr     = 1'b0;
                end
            end
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        for (int k = 0; k < n; k++) tick(an, seg);
    endtask

    function automatic logic [3:0] dig(input int d);
        logic [3:0] m;
        m = 4'b0001 << d;
        return ~m;
    endfunction

    initial begin
        int          v0;
        logic [3:0]  ran;
        logic [6:0]  rseg;
        int          r;

        reset = 1'b1;
        an_n  = '1;
        seg_n = '1;
        do_reset();

        // 1: basic scan of 1,2,3,4
        for (int d = 0; d < 4; d++) hold(dig(d), tbl[d+1], 5);
        hold(4'hF, 7'h7F, 4);
        chk("t1_value", value, 16'h4321);
        chk("t1_err", {15'b0, err}, 16'h0);

        // 2: long dwell on digit 2 samples once
        v0 = nvalid;
        hold(dig(0), tbl[3], 5);
        hold(dig(1), tbl[5], 5);
        hold(dig(2), tbl[8], 50);
        hold(dig(3), tbl[9], 5);
        hold(4'hF, 7'h7F, 4);
        chk("t2_pulses", 16'(nvalid - v0), 16'd1);
        chk("t2_value", value, 16'h9853);

        // 3: undecodable glyph on digit 1, then a clean frame
        hold(dig(0), tbl[10], 5);
        hold(dig(1), 7'b1111111, 5);
        hold(dig(2), tbl[11], 5);
        hold(dig(3), tbl[12], 5);
        hold(4'hF, 7'h7F, 4);
        chk("t3_value", value, 16'hCB0A);
        chk("t3_err", {15'b0, err}, 16'h1);
        hold(dig(0), tbl[15], 5);
        hold(dig(1), tbl[14], 5);
        hold(dig(2), tbl[13], 5);
        hold(dig(3), tbl[0], 5);
        hold(4'hF, 7'h7F, 4);
        chk("t3_clean_err", {15'b0, err}, 16'h0);
        chk("t3_clean_value", value, 16'h0DEF);

        // 4: short dwells are not sampled
        v0 = nvalid;
        for (int d = 0; d < 4; d++) begin
            hold(dig(d), tbl[6], 2);
            hold(4'hF, 7'h7F, 2);
        end
        hold(4'hF, 7'h7F, 4);
        chk("t4_no_valid", 16'(nvalid - v0), 16'd0);
        for (int d = 0; d < 4; d++) hold(dig(d), tbl[6], 5);
        hold(4'hF, 7'h7F, 4);
        chk("t4_value", value, 16'h6666);

        // 5: collision and blank interleaved
        hold(dig(0), tbl[2], 5);
        hold(4'b1100, tbl[7], 6);
        hold(dig(1), tbl[3], 5);
        hold(4'hF, tbl[7], 6);
        hold(dig(2), tbl[4], 5);
        hold(4'b0101, tbl[1], 6);
        hold(dig(3), tbl[5], 5);
        hold(4'hF, 7'h7F, 4);
        chk("t5_value", value, 16'h5432);

        // 6: reset discards a partial frame
        hold(dig(0), tbl[9], 5);
        hold(dig(1), tbl[9], 5);
        hold(dig(2), tbl[9], 5);
        hold(4'hF, 7'h7F, 3);
        do_reset();
        for (int d = 0; d < 4; d++) hold(dig(d), tbl[d+5], 5);
        hold(4'hF, 7'h7F, 4);
        chk("t6_value", value, 16'h8765);

        // random scans
        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) ran = dig(int'($urandom_range(0, 3)));
            else if (r < 85) ran = 4'hF;
            else ran = 4'($urandom);
            r = int'($urandom_range(0, 99));
            if (r < 85) rseg = tbl[$urandom_range(0, 15)];
            else rseg = 7'($urandom);
            hold(ran, rseg, int'($urandom_range(1, 8)));
            if ($urandom_range(0, 99) == 0) do_reset();
        end
        hold(4'hF, 7'h7F, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
